// File: rtl/special_merge.sv
// special_merge: packs the ifmap stream and the three filter-row streams
// onto one shared PE input channel through a single output register.
// Filter rows travel as atomic row1/row2/row3 groups; ifmap beats and
// filter groups take turns when both are waiting.
//
// Handshake: every channel is valid/ready. A producer holds valid and data
// stable until the cycle valid & ready is high, which is the transfer. The
// input readies here are combinational in the input valids, the FSM state
// and out_ready. All readies are low while rst is high.
module special_merge #(
   parameter int FILTER_WIDTH = 8,
   parameter int IFMAP_WIDTH  = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IFMAP_WIDTH-1:0]    ifmap_data,
   input  logic                      ifmap_valid,
   output logic                      ifmap_ready,
   input  logic [3*FILTER_WIDTH-1:0] row1_data,
   input  logic                      row1_valid,
   output logic                      row1_ready,
   input  logic [3*FILTER_WIDTH-1:0] row2_data,
   input  logic                      row2_valid,
   output logic                      row2_ready,
   input  logic [3*FILTER_WIDTH-1:0] row3_data,
   input  logic                      row3_valid,
   output logic                      row3_ready,
   output logic [3*FILTER_WIDTH-1:0] out_data,
   output logic                      out_ifmapb_filter,
   output logic [1:0]                out_filter_row,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [1:0]                dbg_state
);

   localparam int DW = 3 * FILTER_WIDTH;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ROW2 = 2'd1;
   localparam logic [1:0] ROW3 = 2'd2;

   // prio_q = 1 means the filter side was granted last, so ifmap wins a tie.
   logic [1:0]    state_q, state_d;
   logic          prio_q, prio_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_ifmapb_filter_q, out_ifmapb_filter_d;
   logic [1:0]    out_filter_row_q, out_filter_row_d;

   logic can_load;
   logic grant_ifmap, grant_row1, grant_row2, grant_row3;

   // Arbitration: at most one grant per cycle, only when the output slot frees up.
   always_comb begin
      can_load    = !out_valid_q || out_ready;
      grant_ifmap = 1'b0;
      grant_row1  = 1'b0;
      grant_row2  = 1'b0;
      grant_row3  = 1'b0;
      if (!rst && can_load) begin
         case (state_q)
            IDLE: begin
               if (ifmap_valid && (!row1_valid || prio_q)) begin
                  grant_ifmap = 1'b1;
               end else if (row1_valid) begin
                  grant_row1 = 1'b1;
               end
            end
            ROW2:    grant_row2 = row2_valid;
            ROW3:    grant_row3 = row3_valid;
            default: ;
         endcase
      end
   end

   assign ifmap_ready = grant_ifmap;
   assign row1_ready  = grant_row1;
   assign row2_ready  = grant_row2;
   assign row3_ready  = grant_row3;

   // Next state: advance the group FSM and load the output register on a grant.
   always_comb begin
      state_d             = state_q;
      prio_d              = prio_q;
      out_valid_d         = out_valid_q && !out_ready;
      out_data_d          = out_data_q;
      out_ifmapb_filter_d = out_ifmapb_filter_q;
      out_filter_row_d    = out_filter_row_q;
      if (state_q == 2'd3) begin
         state_d = IDLE;
      end
      if (grant_ifmap) begin
         out_valid_d                    = 1'b1;
         out_data_d                     = '0;
         out_data_d[IFMAP_WIDTH-1:0]    = ifmap_data;
         out_ifmapb_filter_d            = 1'b0;
         out_filter_row_d               = 2'b00;
         prio_d                         = 1'b0;
      end else if (grant_row1) begin
         out_valid_d         = 1'b1;
         out_data_d          = row1_data;
         out_ifmapb_filter_d = 1'b1;
         out_filter_row_d    = 2'b00;
         prio_d              = 1'b1;
         state_d             = ROW2;
      end else if (grant_row2) begin
         out_valid_d         = 1'b1;
         out_data_d          = row2_data;
         out_ifmapb_filter_d = 1'b1;
         out_filter_row_d    = 2'b01;
         state_d             = ROW3;
      end else if (grant_row3) begin
         out_valid_d         = 1'b1;
         out_data_d          = row3_data;
         out_ifmapb_filter_d = 1'b1;
         out_filter_row_d    = 2'b10;
         state_d             = IDLE;
      end
   end

   // State and output registers; reset abandons any partial filter group.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q             <= IDLE;
         prio_q              <= 1'b1;
         out_valid_q         <= 1'b0;
         out_data_q          <= '0;
         out_ifmapb_filter_q <= 1'b0;
         out_filter_row_q    <= 2'b00;
      end else begin
         state_q             <= state_d;
         prio_q              <= prio_d;
         out_valid_q         <= out_valid_d;
         out_data_q          <= out_data_d;
         out_ifmapb_filter_q <= out_ifmapb_filter_d;
         out_filter_row_q    <= out_filter_row_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_data_q;
   assign out_ifmapb_filter = out_ifmapb_filter_q;
   assign out_filter_row    = out_filter_row_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_special_merge.sv
// tb_special_merge: directed vectors for special_merge with hand-computed
// expected beats queued ahead of the stimulus.
module tb_special_merge;

   logic        clk;
   logic        rst;
   logic [8:0]  ifmap_data;
   logic        ifmap_valid;
   logic        ifmap_ready;
   logic [23:0] row1_data, row2_data, row3_data;
   logic        row1_valid, row2_valid, row3_valid;
   logic        row1_ready, row2_ready, row3_ready;
   logic [23:0] out_data;
   logic        out_ifmapb_filter;
   logic [1:0]  out_filter_row;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [31:0] exp_q[$];

   special_merge #(.FILTER_WIDTH(8), .IFMAP_WIDTH(9)) dut (
      .clk(clk), .rst(rst),
      .ifmap_data(ifmap_data), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
      .row1_data(row1_data), .row1_valid(row1_valid), .row1_ready(row1_ready),
      .row2_data(row2_data), .row2_valid(row2_valid), .row2_ready(row2_ready),
      .row3_data(row3_data), .row3_valid(row3_valid), .row3_ready(row3_ready),
      .out_data(out_data), .out_ifmapb_filter(out_ifmapb_filter),
      .out_filter_row(out_filter_row), .out_valid(out_valid), .out_ready(out_ready),
      .dbg_state(dbg_state)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] beat(input logic ib, input logic [1:0] row, input logic [23:0] d);
      return {5'd0, ib, row, d};
   endfunction

   // Scoreboard: every transfer on the output is compared with the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            check("out_beat", beat(out_ifmapb_filter, out_filter_row, out_data), exp_q.pop_front());
         end
      end
   end

   // Driver: present one ifmap beat and hold it until accepted.
   task automatic push_ifmap(input logic [8:0] d);
      int n;
      n = 0;
      ifmap_data  = d;
      ifmap_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (ifmap_ready) break;
         n++;
         if (n > 200) begin
            check("ifmap_accept", 32'(ifmap_ready), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1 ifmap_valid = 1'b0;
   endtask

   function automatic logic row_rdy(input int idx);
      case (idx)
         1:       return row1_ready;
         2:       return row2_ready;
         default: return row3_ready;
      endcase
   endfunction

   // Driver: present one beat on filter row idx and hold it until accepted.
   task automatic push_row(input int idx, input logic [23:0] d);
      int n;
      n = 0;
      case (idx)
         1:       begin row1_data = d; row1_valid = 1'b1; end
         2:       begin row2_data = d; row2_valid = 1'b1; end
         default: begin row3_data = d; row3_valid = 1'b1; end
      endcase
      forever begin
         @(negedge clk);
         if (row_rdy(idx)) break;
         n++;
         if (n > 200) begin
            check("row_accept", 32'(row_rdy(idx)), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      case (idx)
         1:       row1_valid = 1'b0;
         2:       row2_valid = 1'b0;
         default: row3_valid = 1'b0;
      endcase
   endtask

   task automatic push_group(input logic [23:0] d1, input logic [23:0] d2, input logic [23:0] d3);
      fork
         push_row(1, d1);
         push_row(2, d2);
         push_row(3, d3);
      join
   endtask

   // Wait (bounded) until every expected beat has left the output.
   task automatic wait_drain();
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      #1;
   endtask

   initial begin
      int t0;
      rst = 1'b1;
      ifmap_data = '0; row1_data = '0; row2_data = '0; row3_data = '0;
      ifmap_valid = 1'b1; row1_valid = 1'b1; row2_valid = 1'b1; row3_valid = 1'b1;
      out_ready = 1'b1;

      // Reset state: outputs cleared and no ready while rst is high
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_ifmapb", 32'(out_ifmapb_filter), 32'd0);
      check("rst_row", 32'(out_filter_row), 32'd0);
      check("rst_readies", {28'd0, ifmap_ready, row1_ready, row2_ready, row3_ready}, 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      ifmap_valid = 1'b0; row1_valid = 1'b0; row2_valid = 1'b0; row3_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Single ifmap beat, zero-extended, latency 1
      exp_q.push_back(beat(1'b0, 2'b00, 24'h0001A5));
      ifmap_data = 9'h1A5; ifmap_valid = 1'b1;
      @(negedge clk);
      check("t1_ifmap_ready", 32'(ifmap_ready), 32'd1);
      @(posedge clk);
      #1 ifmap_valid = 1'b0;
      @(negedge clk);
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_data", 32'(out_data), 32'h0001A5);
      check("t1_ifmap_ready_low", 32'(ifmap_ready), 32'd0);
      wait_drain();

      // Full filter group at one beat per cycle
      exp_q.push_back(beat(1'b1, 2'b00, 24'h112233));
      exp_q.push_back(beat(1'b1, 2'b01, 24'h445566));
      exp_q.push_back(beat(1'b1, 2'b10, 24'h778899));
      t0 = cyc;
      push_group(24'h112233, 24'h445566, 24'h778899);
      check("t2_group_cycles", 32'(cyc - t0), 32'd3);
      wait_drain();

      // Round-robin: ifmap and filter both waiting, groups stay atomic
      exp_q.push_back(beat(1'b0, 2'b00, 24'h000001));
      exp_q.push_back(beat(1'b1, 2'b00, 24'hA00001));
      exp_q.push_back(beat(1'b1, 2'b01, 24'hA00002));
      exp_q.push_back(beat(1'b1, 2'b10, 24'hA00003));
      exp_q.push_back(beat(1'b0, 2'b00, 24'h0001FF));
      exp_q.push_back(beat(1'b1, 2'b00, 24'hB00001));
      exp_q.push_back(beat(1'b1, 2'b01, 24'hB00002));
      exp_q.push_back(beat(1'b1, 2'b10, 24'hB00003));
      exp_q.push_back(beat(1'b0, 2'b00, 24'h0000AA));
      fork
         begin
            push_ifmap(9'h001);
            push_ifmap(9'h1FF);
            push_ifmap(9'h0AA);
         end
         begin
            push_group(24'hA00001, 24'hA00002, 24'hA00003);
            push_group(24'hB00001, 24'hB00002, 24'hB00003);
         end
      join
      wait_drain();

      // Out-of-order rows wait in IDLE until row1 arrives
      row2_data = 24'h445566; row2_valid = 1'b1;
      row3_data = 24'h778899; row3_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_row23_ready", {30'd0, row2_ready, row3_ready}, 32'd0);
         check("t4_out_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      exp_q.push_back(beat(1'b1, 2'b00, 24'h112233));
      exp_q.push_back(beat(1'b1, 2'b01, 24'h445566));
      exp_q.push_back(beat(1'b1, 2'b10, 24'h778899));
      push_group(24'h112233, 24'h445566, 24'h778899);
      wait_drain();

      // Backpressure: beat held for 5 cycles, then resumes without loss
      exp_q.push_back(beat(1'b0, 2'b00, 24'h0000F0));
      exp_q.push_back(beat(1'b0, 2'b00, 24'h00010F));
      out_ready = 1'b0;
      fork
         begin
            push_ifmap(9'h0F0);
            push_ifmap(9'h10F);
         end
         begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("t5_hold_valid", 32'(out_valid), 32'd1);
               check("t5_hold_data", beat(out_ifmapb_filter, out_filter_row, out_data), beat(1'b0, 2'b00, 24'h0000F0));
               check("t5_hold_ready", 32'(ifmap_ready), 32'd0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset mid-group: row1 sent, group abandoned, fresh row1 required
      row1_data = 24'hDEAD01; row1_valid = 1'b1;
      row2_data = 24'hDEAD02; row2_valid = 1'b1;
      row3_data = 24'hDEAD03; row3_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (row1_ready) break;
      end
      @(posedge clk);
      #1;
      check("t6_state_row2", 32'(dbg_state), 32'd1);
      row1_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_readies", {30'd0, row2_ready, row3_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_row2_blocked", {30'd0, row2_ready, out_valid}, 32'd0);
      end
      check("t6_state_idle", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #1;
      exp_q.push_back(beat(1'b1, 2'b00, 24'hA1A2A3));
      exp_q.push_back(beat(1'b1, 2'b01, 24'hB1B2B3));
      exp_q.push_back(beat(1'b1, 2'b10, 24'hC1C2C3));
      push_group(24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3);
      wait_drain();

      repeat (3) @(posedge clk);
      check("exp_q_left", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
